// File: rtl/citi_pkg.sv
// Shared constants, types and coefficient tables for the citi Chebyshev IIR.
// Output reduction (saturate vs. wrap) is selected by the CITI_SAT_EN macro.
package citi_pkg;

  localparam int N     = 8;
  localparam int W     = 16;
  localparam int CW    = 16;
  localparam int FRAC  = 14;
  localparam int ACCW  = 40;
  localparam int NTAPS = 2 * N + 1;

  typedef logic signed [W-1:0]  sample_t;
  typedef logic signed [CW-1:0] coef_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MAC,
    S_DONE
  } state_e;

  // Low-pass design, Q2.14; feedback taps sum to well under 1.0 in magnitude.
  localparam coef_t B_COEF [0:N] = '{
    16'sd82, 16'sd655, 16'sd2293, 16'sd4587, 16'sd5734,
    16'sd4587, 16'sd2293, 16'sd655, 16'sd82
  };

  localparam coef_t A_COEF [1:N] = '{
    -16'sd6554, 16'sd4096, -16'sd1638, 16'sd819,
    -16'sd328, 16'sd164, -16'sd82, 16'sd33
  };

  function automatic sample_t reduce_out(input logic signed [ACCW-1:0] acc);
`ifdef CITI_SAT_EN
    logic signed [ACCW-1:0] sh;
    sh = acc >>> FRAC;
    // Fits in W bits only when every bit above the sample sign bit matches it.
    if (sh[ACCW-1:W-1] != {(ACCW-W+1){sh[W-1]}})
      return sh[ACCW-1] ? 16'sh8000 : 16'sh7fff;
    else
      return sh[W-1:0];
`else
    return W'(acc >>> FRAC);
`endif
  endfunction

endpackage

// File: rtl/citi_mac.sv
// Time-shared signed multiply-accumulate: one coef*sample product per enabled
// cycle, added or subtracted into an ACCW-bit accumulator with synchronous clear.
module citi_mac
  import citi_pkg::*;
(
  input  logic                   clk30x,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   sub,
  input  coef_t                  coef,
  input  sample_t                data,
  output logic signed [ACCW-1:0] acc
);

  logic signed [CW+W-1:0] prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] acc_d, acc_q;

  always_comb begin
    prod     = (CW+W)'(coef) * (CW+W)'(data);
    prod_ext = ACCW'(prod);
    acc_d    = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = sub ? acc_q - prod_ext : acc_q + prod_ext;
  end

  always_ff @(posedge clk30x) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/citi.sv
// 8th-order direct-form-I Chebyshev low-pass IIR, one shared MAC stepped over
// all 17 taps per sample strobe. CITI_SAT_EN selects saturating output.
module citi
  import citi_pkg::*;
(
  input  logic         clk30x,
  input  logic         rst,
  input  logic [W-1:0] xin,
  output logic [W-1:0] yout,
  output logic [W-1:0] xin_del,
  input  logic         donext
);

  state_e  state_q, state_d;
  logic [4:0] k_q, k_d;
  sample_t x_q [0:N];
  sample_t x_d [0:N];
  sample_t y_q [0:N-1];
  sample_t y_d [0:N-1];
  sample_t yout_q, yout_d, xin_del_q, xin_del_d;
  sample_t y_new;

  logic    mac_clr, mac_en, mac_sub;
  coef_t   mac_coef;
  sample_t mac_data;
  logic signed [ACCW-1:0] acc;
  logic [3:0] fb_idx;
  logic [2:0] y_idx;

  // Taps 0..N walk the feed-forward side, N+1..2N the feedback side.
  always_comb begin
    fb_idx = 4'(k_q - 5'(N));
    y_idx  = 3'(fb_idx - 4'd1);
    if (k_q <= 5'(N)) begin
      mac_coef = B_COEF[k_q[3:0]];
      mac_data = x_q[k_q[3:0]];
      mac_sub  = 1'b0;
    end else begin
      mac_coef = A_COEF[fb_idx];
      mac_data = y_q[y_idx];
      mac_sub  = 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    x_d       = x_q;
    y_d       = y_q;
    yout_d    = yout_q;
    xin_del_d = xin_del_q;
    mac_en    = 1'b0;
    mac_clr   = 1'b0;
    y_new     = reduce_out(acc);
    case (state_q)
      S_IDLE: begin
        if (donext) begin
          for (int i = N; i > 0; i--) x_d[i] = x_q[i-1];
          x_d[0]  = xin;
          k_d     = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        mac_en = 1'b1;
        if (k_q == 5'(NTAPS-1)) state_d = S_DONE;
        else                    k_d     = k_q + 5'd1;
      end
      S_DONE: begin
        yout_d    = y_new;
        xin_del_d = x_q[0];
        for (int i = N-1; i > 0; i--) y_d[i] = y_q[i-1];
        y_d[0]    = y_new;
        mac_clr   = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk30x) begin
    if (rst) begin
      state_q   <= S_IDLE;
      k_q       <= '0;
      x_q       <= '{default: '0};
      y_q       <= '{default: '0};
      yout_q    <= '0;
      xin_del_q <= '0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      x_q       <= x_d;
      y_q       <= y_d;
      yout_q    <= yout_d;
      xin_del_q <= xin_del_d;
    end
  end

  citi_mac u_mac (
    .clk30x (clk30x),
    .rst    (rst),
    .clr    (mac_clr),
    .en     (mac_en),
    .sub    (mac_sub),
    .coef   (mac_coef),
    .data   (mac_data),
    .acc    (acc)
  );

  assign yout    = yout_q;
  assign xin_del = xin_del_q;

endmodule

// File: tb/tb_citi.sv
// Directed + randomized bench for citi against a difference-equation model.
module tb_citi;

  logic        clk30x;
  logic        rst;
  logic [15:0] xin;
  logic [15:0] yout;
  logic [15:0] xin_del;
  logic        donext;

  citi dut (
    .clk30x  (clk30x),
    .rst     (rst),
    .xin     (xin),
    .yout    (yout),
    .xin_del (xin_del),
    .donext  (donext)
  );

  initial clk30x = 1'b0;
  always #5 clk30x = ~clk30x;

  int n_vec = 0;
  int n_err = 0;

  int BC [0:8] = '{82, 655, 2293, 4587, 5734, 4587, 2293, 655, 82};
  int AC [1:8] = '{-6554, 4096, -1638, 819, -328, 164, -82, 33};

  int xh [0:8];
  int yh [0:7];
  logic [15:0] exp_y, exp_d;

  logic [15:0] pvec [0:7] = '{16'h1000, 16'h3a7c, 16'hc350, 16'h7fff,
                              16'h8000, 16'h0123, 16'hf00d, 16'h2468};

  task automatic tick;
    @(posedge clk30x);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic model_reset;
    for (int i = 0; i < 9; i++) xh[i] = 0;
    for (int i = 0; i < 8; i++) yh[i] = 0;
    exp_y = '0;
    exp_d = '0;
  endtask

  // y[n] = (sum b_k x[n-k] - sum a_k y[n-k]) >> 14, then reduced to 16 bits
  task automatic model_step(input logic [15:0] xv);
    longint acc, sh;
    int r;
    for (int i = 8; i > 0; i--) xh[i] = xh[i-1];
    xh[0] = int'($signed(xv));
    acc = 0;
    for (int k = 0; k <= 8; k++) acc += longint'(BC[k]) * longint'(xh[k]);
    for (int k = 1; k <= 8; k++) acc -= longint'(AC[k]) * longint'(yh[k-1]);
    sh = acc >>> 14;
`ifdef CITI_SAT_EN
    if (sh > 32767)       r = 32767;
    else if (sh < -32768) r = -32768;
    else                  r = int'(sh);
`else
    r = int'($signed(sh[15:0]));
`endif
    for (int i = 7; i > 0; i--) yh[i] = yh[i-1];
    yh[0] = r;
    exp_y = 16'(r);
    exp_d = xv;
  endtask

  // One 30-cycle sample period; optional early strobe or mid-MAC reset at cycle offset.
  task automatic strobe(input logic [15:0] xv, input int early, input int rst_at);
    logic [15:0] prev_y;
    prev_y = exp_y;
    donext = 1'b1;
    xin    = xv;
    tick;
    donext = 1'b0;
    xin    = 16'($urandom);
    for (int i = 1; i <= 17; i++) begin
      if (i == early) begin
        donext = 1'b1;
        xin    = 16'ha5a5;
      end
      if (i == rst_at) rst = 1'b1;
      tick;
      donext = 1'b0;
      if (i == rst_at) begin
        rst = 1'b0;
        model_reset;
        check("rst_mid_yout", yout, exp_y);
        check("rst_mid_xin_del", xin_del, exp_d);
        repeat (29 - i) tick;
        return;
      end
    end
    check("latency_hold", yout, prev_y);
    model_step(xv);
    tick;
    check("yout", yout, exp_y);
    check("xin_del", xin_del, exp_d);
    repeat (11) tick;
  endtask

  initial begin
    rst    = 1'b1;
    donext = 1'b0;
    xin    = '0;
    model_reset;
    tick;
    donext = 1'b1;
    xin    = 16'h1234;
    tick;
    donext = 1'b0;
    check("reset_yout", yout, 16'h0000);
    check("reset_xin_del", xin_del, 16'h0000);
    rst = 1'b0;
    repeat (25) tick;
    check("strobe_in_reset_yout", yout, 16'h0000);

    repeat (24) strobe(16'h0000, 0, 0);

    strobe(16'h4000, 0, 0);
    check("impulse_first", yout, 16'd82);
    repeat (15) strobe(16'h0000, 0, 0);

    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 8; i++) strobe(pvec[i], 0, 0);

    repeat (30) strobe(16'($urandom), 0, 0);

    for (int i = 0; i < 12; i++) strobe((i % 2) ? 16'h8000 : 16'h7fff, 0, 0);
    repeat (16) strobe(16'h7fff, 0, 0);
    repeat (8)  strobe(16'h8000, 0, 0);

    strobe(16'h0800, 5, 0);
    strobe(16'h0400, 0, 0);

    strobe(16'h3000, 0, 7);
    repeat (6) strobe(16'($urandom), 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
